// File: rtl/ov7670_fb_pkg.sv
// Shared state encodings and constants for the OV7670 ping-pong frame-buffer controller.
package ov7670_fb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_WAIT_SOF = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_PENDING  = 3'd4,
        ST_ERR      = 3'd5
    } fb_state_t;

    localparam int unsigned DEF_FRAME_TIMEOUT = 2_000_000;
    localparam int unsigned BANK_W            = 1;

    // States in which a stalled camera is being watched for.
    function automatic logic is_watched(input fb_state_t s);
        return (s == ST_WAIT_SOF) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/ov7670_fb_watchdog.sv
// Camera-stall watchdog: counts enabled cycles since the last clear and flags the final allowed cycle.
module ov7670_fb_watchdog
    import ov7670_fb_pkg::*;
#(
    parameter int unsigned FRAME_TIMEOUT = DEF_FRAME_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_n_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned   CW   = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_TIMEOUT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] r_count;

    // Cycle counter; holds at the last value so it can never wrap back to a safe count.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/ov7670_frame_buffer_ctrl.sv
// Ping-pong frame-buffer controller: sequences camera captures, gates BRAM writes to whole
// frames and swaps the write/read banks only on a VGA frame boundary.
module ov7670_frame_buffer_ctrl
    import ov7670_fb_pkg::*;
#(
    parameter int unsigned FRAME_TIMEOUT = DEF_FRAME_TIMEOUT,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_n_reset,
    input  logic             i_mode,
    input  logic             i_capture_req,
    input  logic             i_cam_frame_start,
    input  logic             i_cam_frame_end,
    input  logic             i_vga_frame_start,
    output logic             o_start_capture,
    output logic             o_wr_en,
    output logic             o_wr_bank,
    output logic             o_rd_bank,
    output logic             o_frame_ready,
    output logic             o_timeout,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_frame_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    fb_state_t         r_state;
    fb_state_t         w_next;
    logic              w_swap;
    logic              w_wd_clear;
    logic              w_wd_enable;
    logic              w_wd_expired;
    logic [BANK_W-1:0] r_wr_bank;
    logic [BANK_W-1:0] r_rd_bank;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic              r_start_capture;
    logic              r_wr_en;
    logic              r_frame_ready;
    logic              r_timeout;

    assign w_swap      = (r_state == ST_PENDING) && i_vga_frame_start;
    assign w_wd_enable = is_watched(r_state);
    // A repeated camera frame start mid-capture proves the camera is alive, so restart the count.
    assign w_wd_clear  = (w_next != r_state) || ((r_state == ST_CAPTURE) && i_cam_frame_start);

    ov7670_fb_watchdog #(
        .FRAME_TIMEOUT (FRAME_TIMEOUT)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_n_reset (i_n_reset),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_expired (w_wd_expired)
    );

    // Next-state decode; frame_end takes priority over everything else seen in CAPTURE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!i_mode || i_capture_req) w_next = ST_ARM;
                else                          w_next = ST_IDLE;
            end
            ST_ARM: begin
                w_next = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (i_cam_frame_start)  w_next = ST_CAPTURE;
                else if (w_wd_expired)  w_next = ST_ERR;
                else                    w_next = ST_WAIT_SOF;
            end
            ST_CAPTURE: begin
                if (i_cam_frame_end)         w_next = ST_PENDING;
                else if (i_cam_frame_start)  w_next = ST_CAPTURE;
                else if (w_wd_expired)       w_next = ST_ERR;
                else                         w_next = ST_CAPTURE;
            end
            ST_PENDING: begin
                if (i_vga_frame_start) w_next = ST_IDLE;
                else                   w_next = ST_PENDING;
            end
            ST_ERR: begin
                if (i_capture_req) w_next = ST_IDLE;
                else               w_next = ST_ERR;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register with outputs decoded from the next state so each is a flop.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_state         <= ST_IDLE;
            r_start_capture <= 1'b0;
            r_wr_en         <= 1'b0;
            r_frame_ready   <= 1'b0;
            r_timeout       <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_start_capture <= (w_next == ST_ARM);
            r_wr_en         <= (w_next == ST_CAPTURE);
            r_frame_ready   <= (w_next == ST_PENDING);
            r_timeout       <= (w_next == ST_ERR);
        end
    end

    // Bank assignment and completed-frame counter advance together on a swap.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b1;
            r_frame_cnt <= '0;
        end else if (w_swap) begin
            r_wr_bank   <= ~r_wr_bank;
            r_rd_bank   <= ~r_rd_bank;
            r_frame_cnt <= r_frame_cnt + CNT_ONE;
        end else begin
            r_wr_bank   <= r_wr_bank;
            r_rd_bank   <= r_rd_bank;
            r_frame_cnt <= r_frame_cnt;
        end
    end

    assign o_start_capture = r_start_capture;
    assign o_wr_en         = r_wr_en;
    assign o_wr_bank       = r_wr_bank;
    assign o_rd_bank       = r_rd_bank;
    assign o_frame_ready   = r_frame_ready;
    assign o_timeout       = r_timeout;
    assign o_state         = r_state;
    assign o_frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_ov7670_frame_buffer_ctrl.sv
// Directed bench for ov7670_frame_buffer_ctrl with hand-computed expected values.
module tb_ov7670_frame_buffer_ctrl;

    localparam int unsigned TB_TIMEOUT = 100;
    // Narrow counter so the wrap scenario stays short; wrap is 255 -> 0.
    localparam int unsigned TB_CNT_W   = 8;

    logic                clk = 1'b0;
    logic                n_reset;
    logic                mode;
    logic                capture_req;
    logic                cam_fs;
    logic                cam_fe;
    logic                vga_fs;
    logic                start_capture;
    logic                wr_en;
    logic                wr_bank;
    logic                rd_bank;
    logic                frame_ready;
    logic                timeout;
    logic [2:0]          state;
    logic [TB_CNT_W-1:0] frame_cnt;

    int n_vec = 0;
    int n_err = 0;
    int bad;

    always #5 clk = ~clk;

    ov7670_frame_buffer_ctrl #(
        .FRAME_TIMEOUT (TB_TIMEOUT),
        .CNT_W         (TB_CNT_W)
    ) dut (
        .i_clk             (clk),
        .i_n_reset         (n_reset),
        .i_mode            (mode),
        .i_capture_req     (capture_req),
        .i_cam_frame_start (cam_fs),
        .i_cam_frame_end   (cam_fe),
        .i_vga_frame_start (vga_fs),
        .o_start_capture   (start_capture),
        .o_wr_en           (wr_en),
        .o_wr_bank         (wr_bank),
        .o_rd_bank         (rd_bank),
        .o_frame_ready     (frame_ready),
        .o_timeout         (timeout),
        .o_state           (state),
        .o_frame_cnt       (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        cam_fs = 1'b1; tick(); cam_fs = 1'b0;
    endtask

    task automatic pulse_fe();
        cam_fe = 1'b1; tick(); cam_fe = 1'b0;
    endtask

    task automatic pulse_vga();
        vga_fs = 1'b1; tick(); vga_fs = 1'b0;
    endtask

    task automatic pulse_req();
        capture_req = 1'b1; tick(); capture_req = 1'b0;
    endtask

    initial begin
        n_reset = 1'b0; mode = 1'b0; capture_req = 1'b0;
        cam_fs = 1'b0; cam_fe = 1'b0; vga_fs = 1'b0;
        repeat (3) tick();

        chk("rst_state",   32'(state), 32'd0);
        chk("rst_wr_bank", 32'(wr_bank), 32'd0);
        chk("rst_rd_bank", 32'(rd_bank), 32'd1);
        chk("rst_cnt",     32'(frame_cnt), 32'd0);
        chk("rst_outs",    32'({start_capture, wr_en, frame_ready, timeout}), 32'd0);

        // Continuous mode: IDLE -> ARM -> WAIT_SOF
        n_reset = 1'b1;
        tick();
        chk("c_arm_state", 32'(state), 32'd1);
        chk("c_arm_start", 32'(start_capture), 32'd1);
        tick();
        chk("c_wsof_state", 32'(state), 32'd2);
        chk("c_wsof_start", 32'(start_capture), 32'd0);
        chk("c_wsof_wr_en", 32'(wr_en), 32'd0);
        vga_fs = 1'b1; cam_fe = 1'b1; tick(); vga_fs = 1'b0; cam_fe = 1'b0;
        chk("c_ignored_state", 32'(state), 32'd2);
        pulse_fs();
        chk("c_cap_state", 32'(state), 32'd3);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (wr_en !== 1'b1) bad++;
            tick();
        end
        chk("c_wr_en_window", 32'(bad), 32'd0);
        pulse_fe();
        chk("c_pend_state", 32'(state), 32'd4);
        chk("c_pend_wr_en", 32'(wr_en), 32'd0);
        chk("c_pend_ready", 32'(frame_ready), 32'd1);
        repeat (4) tick();
        chk("c_pend_hold_bank", 32'(wr_bank), 32'd0);
        pulse_vga();
        chk("c_swap_state", 32'(state), 32'd0);
        chk("c_swap_banks", 32'({wr_bank, rd_bank}), 32'b10);
        chk("c_swap_cnt",   32'(frame_cnt), 32'd1);
        chk("c_swap_ready", 32'(frame_ready), 32'd0);
        tick();
        chk("c_rearm_start", 32'(start_capture), 32'd1);
        tick();
        chk("c_rearm_state", 32'(state), 32'd2);

        // Switch to single-shot mid-frame; takes effect after this frame
        mode = 1'b1;
        pulse_fs();
        pulse_fe();
        pulse_vga();
        chk("m_swap_cnt",   32'(frame_cnt), 32'd2);
        chk("m_swap_banks", 32'({wr_bank, rd_bank}), 32'b01);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (state !== 3'd0 || start_capture !== 1'b0) bad++;
        end
        chk("s_idle_1000", 32'(bad), 32'd0);

        // Single-shot frame
        pulse_req();
        chk("s_arm_start", 32'(start_capture), 32'd1);
        tick();
        pulse_fs();
        chk("s_cap_wr_en", 32'(wr_en), 32'd1);
        capture_req = 1'b1; tick(); capture_req = 1'b0;
        chk("s_req_ignored", 32'(state), 32'd3);
        pulse_fe();
        pulse_vga();
        chk("s_swap_cnt",   32'(frame_cnt), 32'd3);
        chk("s_swap_banks", 32'({wr_bank, rd_bank}), 32'b10);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state !== 3'd0 || start_capture !== 1'b0) bad++;
        end
        chk("s_no_rearm", 32'(bad), 32'd0);

        // frame_end and vga_frame_start in the same CAPTURE cycle
        pulse_req();
        tick();
        pulse_fs();
        cam_fe = 1'b1; vga_fs = 1'b1; tick(); cam_fe = 1'b0; vga_fs = 1'b0;
        chk("sim_state", 32'(state), 32'd4);
        chk("sim_ready", 32'(frame_ready), 32'd1);
        chk("sim_cnt",   32'(frame_cnt), 32'd3);
        chk("sim_bank",  32'(wr_bank), 32'd1);
        tick();
        pulse_vga();
        chk("sim_swap_cnt",  32'(frame_cnt), 32'd4);
        chk("sim_swap_bank", 32'({wr_bank, rd_bank}), 32'b01);

        // Timeout in WAIT_SOF: entry at N, ERR at N+100
        pulse_req();
        tick();
        chk("to_wsof", 32'(state), 32'd2);
        repeat (TB_TIMEOUT - 1) tick();
        chk("to_pre_state",   32'(state), 32'd2);
        chk("to_pre_timeout", 32'(timeout), 32'd0);
        tick();
        chk("to_state",   32'(state), 32'd5);
        chk("to_timeout", 32'(timeout), 32'd1);
        repeat (5) tick();
        chk("to_sticky", 32'(timeout), 32'd1);
        pulse_req();
        chk("to_clr_state",   32'(state), 32'd0);
        chk("to_clr_timeout", 32'(timeout), 32'd0);

        // Repeated frame_start in CAPTURE restarts the watchdog
        pulse_req();
        tick();
        pulse_fs();
        repeat (60) tick();
        pulse_fs();
        repeat (TB_TIMEOUT - 1) tick();
        chk("wd_restart_state", 32'(state), 32'd3);
        tick();
        chk("wd_cap_state", 32'(state), 32'd5);
        chk("wd_cap_wr_en", 32'(wr_en), 32'd0);
        pulse_req();
        chk("wd_clr_state", 32'(state), 32'd0);

        // Counter wrap: 4 frames done, 251 more -> 255, one more -> 0
        mode = 1'b0;
        for (int f = 0; f < 251; f++) begin
            tick(); tick();
            pulse_fs(); pulse_fe(); pulse_vga();
        end
        chk("wrap_max", 32'(frame_cnt), 32'd255);
        tick(); tick();
        pulse_fs(); pulse_fe(); pulse_vga();
        chk("wrap_zero",  32'(frame_cnt), 32'd0);
        chk("wrap_banks", 32'({wr_bank, rd_bank}), 32'b01);

        // Reset mid-capture with banks at 1/0
        tick(); tick();
        pulse_fs(); pulse_fe(); pulse_vga();
        chk("pre_rst_banks", 32'({wr_bank, rd_bank}), 32'b10);
        tick(); tick();
        pulse_fs();
        chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
        n_reset = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_banks", 32'({wr_bank, rd_bank}), 32'b01);
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_cnt",   32'(frame_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
